// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined adder/subtractor.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Bits handled by each pipeline stage; guarded so a bad STAGES cannot divide by zero.
    function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

    function automatic bit params_legal(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One carry chunk of the pipelined adder: CW-bit add with carry-in/out and its stage register.
module adder_pipe_stage
    import adder_pkg::*;
#(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    input  logic          in_valid,
    input  logic [CW-1:0] in_a,
    input  logic [CW-1:0] in_b,
    input  logic          in_cin,
    output logic          out_valid,
    output logic [CW-1:0] out_sum,
    output logic          out_cout,
    output logic          out_ovf
);

    logic [CW:0] sum_c;

    assign sum_c = {1'b0, in_a} + {1'b0, in_b} + (CW + 1)'(in_cin);

    // Overflow is only meaningful on the chunk holding the operand sign bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (advance) begin
            out_valid <= in_valid;
            out_sum   <= sum_c[CW-1:0];
            out_cout  <= sum_c[CW];
            out_ovf   <= (in_a[CW-1] == in_b[CW-1]) && (sum_c[CW-1] != in_a[CW-1]);
        end
    end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder/subtractor split into STAGES registered carry chunks.
// Subtract support is built only when ADDER_PIPE_SUB_EN is defined.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_ovf
);

    localparam int unsigned CW   = chunk_width(WIDTH, STAGES);
    localparam int unsigned LAST = STAGES - 1;

    if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
        $error("adder_pipe: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin0;

`ifdef ADDER_PIPE_SUB_EN
    op_e op;

    assign op    = op_e'(in_sub);
    assign b_eff = (op == OP_SUB) ? ~in_b : in_b;
    assign cin0  = (op == OP_SUB);
`else
    logic sub_unused;

    assign sub_unused = in_sub;
    assign b_eff      = in_b;
    assign cin0       = 1'b0;
`endif

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned UPW = WIDTH - CW * k;

        logic [UPW-1:0]        a_up;
        logic [UPW-1:0]        b_up;
        logic                  cin;
        logic                  vin;
        logic                  v_q;
        logic                  c_q;
        logic                  ovf_q;
        logic [CW-1:0]         s_q;
        logic [(k+1)*CW-1:0]   acc;

        if (k == 0) begin : g_head
            assign a_up = in_a;
            assign b_up = b_eff;
            assign cin  = cin0;
            assign vin  = in_valid;
            assign acc  = s_q;
        end else begin : g_body
            logic [k*CW-1:0] lo_q;

            // Skew the still-unused operand chunks forward, deskew finished sum chunks alongside.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_up <= '0;
                    b_up <= '0;
                    lo_q <= '0;
                end else if (advance) begin
                    a_up <= g_stage[k-1].a_up[UPW+CW-1:CW];
                    b_up <= g_stage[k-1].b_up[UPW+CW-1:CW];
                    lo_q <= g_stage[k-1].acc;
                end
            end

            assign cin = g_stage[k-1].c_q;
            assign vin = g_stage[k-1].v_q;
            assign acc = {s_q, lo_q};
        end

        adder_pipe_stage #(
            .CW(CW)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .advance  (advance),
            .in_valid (vin),
            .in_a     (a_up[CW-1:0]),
            .in_b     (b_up[CW-1:0]),
            .in_cin   (cin),
            .out_valid(v_q),
            .out_sum  (s_q),
            .out_cout (c_q),
            .out_ovf  (ovf_q)
        );

        if (k == LAST) begin : g_tail
            assign out_valid = v_q;
            assign out_sum   = {c_q, acc};
            assign out_ovf   = ovf_q;
        end else begin : g_mid
            logic ovf_unused;

            assign ovf_unused = ovf_q;
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// Directed self-checking bench for adder_pipe (16-bit/4-stage and 4-bit/1-stage instances).
module tb_adder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sub, out_valid, out_ready, out_ovf;
    logic [15:0] in_a, in_b;
    logic [16:0] out_sum;

    logic        s_in_valid, s_in_ready, s_in_sub, s_out_valid, s_out_ready, s_out_ovf;
    logic [3:0]  s_in_a, s_in_b;
    logic [4:0]  s_out_sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
    );

    adder_pipe #(.WIDTH(4), .STAGES(1)) u_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_sub(s_in_sub), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_sum(s_out_sum), .out_ovf(s_out_ovf)
    );

    // Stimulus driver only: issues one operation into an idle pipe and records result and latency.
    task automatic run_single(input logic [15:0] a, input logic [15:0] b, input logic sub,
                              output logic [16:0] sum, output logic ovf, output int lat);
        @(posedge clk); #1;
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
        lat = 0; sum = '0; ovf = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (i == 1) in_valid = 1'b0;
            if (out_valid) begin
                lat = i; sum = out_sum; ovf = out_ovf;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_sum !== 17'h0) begin errors++; $display("FAIL reset_out_sum got %h exp 0", out_sum); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b exp 0", out_ovf); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (s_out_valid !== 1'b0 || s_in_ready !== 1'b0) begin errors++; $display("FAIL reset_small got valid %b ready %b exp 0 0", s_out_valid, s_in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL release_small_in_ready got %b exp 1", s_in_ready); end
    endtask

    task automatic test_add;
        logic [16:0] sum; logic ovf; int lat;
        run_single(16'hFFFF, 16'h0001, 1'b0, sum, ovf, lat);
        checks++; if (sum !== 17'h1_0000) begin errors++; $display("FAIL add_carry_sum got %h exp 10000", sum); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL add_carry_ovf got %b exp 0", ovf); end
        checks++; if (lat != 4) begin errors++; $display("FAIL add_latency got %0d exp 4", lat); end
        run_single(16'h7FFF, 16'h0001, 1'b0, sum, ovf, lat);
        checks++; if (sum !== 17'h0_8000 || ovf !== 1'b1) begin errors++; $display("FAIL add_signed_ovf got %h/%b exp 08000/1", sum, ovf); end
        run_single(16'h8000, 16'h8000, 1'b0, sum, ovf, lat);
        checks++; if (sum !== 17'h1_0000 || ovf !== 1'b1) begin errors++; $display("FAIL add_neg_ovf got %h/%b exp 10000/1", sum, ovf); end
        run_single(16'h1234, 16'h0FCD, 1'b0, sum, ovf, lat);
        checks++; if (sum !== 17'h0_2201 || ovf !== 1'b0) begin errors++; $display("FAIL add_chunk_carry got %h/%b exp 02201/0", sum, ovf); end
    endtask

    task automatic test_sub;
        logic [16:0] sum; logic ovf; int lat;
        logic [16:0] e1, e2, e3; logic o3;
`ifdef ADDER_PIPE_SUB_EN
        e1 = 17'h0_FFFE; e2 = 17'h1_0002; e3 = 17'h1_7FFF; o3 = 1'b1;
`else
        e1 = 17'h0_000C; e2 = 17'h0_000C; e3 = 17'h0_8001; o3 = 1'b0;
`endif
        run_single(16'h0005, 16'h0007, 1'b1, sum, ovf, lat);
        checks++; if (sum !== e1 || ovf !== 1'b0) begin errors++; $display("FAIL sub_borrow got %h/%b exp %h/0", sum, ovf, e1); end
        checks++; if (lat != 4) begin errors++; $display("FAIL sub_latency got %0d exp 4", lat); end
        run_single(16'h0007, 16'h0005, 1'b1, sum, ovf, lat);
        checks++; if (sum !== e2 || ovf !== 1'b0) begin errors++; $display("FAIL sub_no_borrow got %h/%b exp %h/0", sum, ovf, e2); end
        run_single(16'h8000, 16'h0001, 1'b1, sum, ovf, lat);
        checks++; if (sum !== e3 || ovf !== o3) begin errors++; $display("FAIL sub_ovf got %h/%b exp %h/%b", sum, ovf, e3, o3); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] ta [8] = '{16'h0001, 16'h00FF, 16'h0F0F, 16'hFFFF, 16'h8000, 16'h4000, 16'hABCD, 16'hC000};
        logic [15:0] tb [8] = '{16'h0002, 16'h0001, 16'hF0F0, 16'hFFFF, 16'h7FFF, 16'h4000, 16'h1234, 16'h4000};
        logic [16:0] ts [8] = '{17'h00003, 17'h00100, 17'h0FFFF, 17'h1FFFE, 17'h0FFFF, 17'h08000, 17'h0BE01, 17'h10000};
        logic        to [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int sent = 0;
        int rcvd = 0;
        logic [16:0] held = '0;
        for (int c = 0; c < 40 && rcvd < 8; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= 5 && c <= 7);
            in_valid  = (sent < 8);
            in_sub    = 1'b0;
            if (sent < 8) begin in_a = ta[sent]; in_b = tb[sent]; end
            #1;
            if (c >= 5 && c <= 7) begin
                checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready c%0d got valid %b ready %b exp 1 0", c, out_valid, in_ready); end
                if (c == 5) held = out_sum;
                else begin
                    checks++; if (out_sum !== held) begin errors++; $display("FAIL stall_hold c%0d got %h exp %h", c, out_sum, held); end
                end
            end
            if (out_valid && out_ready) begin
                checks++; if (out_sum !== ts[rcvd] || out_ovf !== to[rcvd]) begin errors++; $display("FAIL b2b_result %0d got %h/%b exp %h/%b", rcvd, out_sum, out_ovf, ts[rcvd], to[rcvd]); end
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (rcvd != 8) begin errors++; $display("FAIL b2b_count got %0d exp 8", rcvd); end
    endtask

    task automatic test_reset_mid;
        logic [16:0] sum; logic ovf; int lat;
        int leaked = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_sub = 1'b0; in_a = 16'(c * 16 + 1); in_b = 16'h0100;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got %b exp 1", out_valid); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_sum !== 17'h0) begin errors++; $display("FAIL midrst_async got valid %b sum %h exp 0 0", out_valid, out_sum); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b exp 0", in_ready); end
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid) leaked++;
        end
        checks++; if (leaked != 0) begin errors++; $display("FAIL midrst_leak got %0d exp 0", leaked); end
        run_single(16'h0100, 16'h0020, 1'b0, sum, ovf, lat);
        checks++; if (sum !== 17'h0_0120 || lat != 4) begin errors++; $display("FAIL midrst_next got %h lat %0d exp 00120 lat 4", sum, lat); end
    endtask

    task automatic test_small_exhaustive;
        logic [4:0] exp_sum; logic exp_ovf; logic [3:0] a, b;
        s_out_ready = 1'b1; s_in_sub = 1'b0;
        @(posedge clk); #1;
        s_in_valid = 1'b1; s_in_a = 4'h9; s_in_b = 4'h8;
        #1;
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL small_pre_valid got %b exp 0", s_out_valid); end
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        checks++; if (s_out_valid !== 1'b1 || s_out_sum !== 5'h11) begin errors++; $display("FAIL small_latency got %b/%h exp 1/11", s_out_valid, s_out_sum); end
        for (int i = 0; i <= 256; i++) begin
            @(posedge clk); #1;
            if (i < 256) begin
                s_in_valid = 1'b1; s_in_a = 4'(i / 16); s_in_b = 4'(i % 16);
            end else s_in_valid = 1'b0;
            if (i > 0) begin
                a = 4'((i - 1) / 16); b = 4'((i - 1) % 16);
                exp_sum = {1'b0, a} + {1'b0, b};
                exp_ovf = (a[3] == b[3]) && (exp_sum[3] != a[3]);
                checks++;
                if (s_out_valid !== 1'b1 || s_out_sum !== exp_sum || s_out_ovf !== exp_ovf) begin
                    errors++; $display("FAIL small_pair %h+%h got %b/%h/%b exp 1/%h/%b", a, b, s_out_valid, s_out_sum, s_out_ovf, exp_sum, exp_ovf);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_sub = 1'b0; s_out_ready = 1'b1;
        test_reset;
        test_add;
        test_sub;
        test_back_to_back;
        test_reset_mid;
        test_small_exhaustive;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined two-operand adder/subtractor with valid/ready handshakes on both sides. It generalises the team's fixed 4-bit ripple adder to WIDTH bits. The carry chain is split into STAGES registered chunks, so wide adds close timing at full clock rate with throughput of one operation per cycle. It sits between operand producers (register file or datapath muxes) and any downstream consumer able to apply backpressure.

## Interface
- WIDTH, 16: operand width in bits; must be a multiple of STAGES.
- STAGES, 4: pipeline depth and number of carry chunks; 1 ≤ STAGES ≤ WIDTH; chunk width CW = WIDTH/STAGES.
- clk  in  1: sole clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- in_valid  in  1: operand bundle valid.
- in_ready  out  1: block can accept operands this cycle.
- in_a  in  WIDTH: operand A, unsigned or two's complement.
- in_b  in  WIDTH: operand B.
- in_sub  in  1: 1 = A − B, 0 = A + B (see Configuration).
- out_valid  out  1: result valid.
- out_ready  in  1: consumer accepts result this cycle.
- out_sum  out  WIDTH+1: result; bit WIDTH is carry-out (subtract: 1 = no borrow).
- out_ovf  out  1: signed two's-complement overflow of the WIDTH-bit result.

## Operation
- Subtract is computed as A + ~B + 1; stage 0 carry-in = in_sub; add has carry-in 0.
- Stage k adds chunk k of A and B' (B' = B or ~B) plus the registered carry from stage k−1, then registers CW sum bits and a carry.
- Upper operand chunks travel through skew registers to their stage. Lower sum chunks travel through deskew registers so all WIDTH bits emerge together.
- out_ovf = (A[W−1] == B'[W−1]) && (sum[W−1] != A[W−1]), evaluated in the last stage from carried-along sign bits.
- Each stage has a valid bit. Global advance = !out_valid || out_ready. All stage registers, including valid bits, load only on advance and hold otherwise.
- in_ready = advance while rst is low; in_ready = 0 while rst is high.
- Bubbles are not collapsed; an empty slot stays empty and moves with the pipe.
- Ordering is strictly FIFO; no transaction is dropped or duplicated under any out_ready pattern.

## Timing
- Reset (async assert, registers released on the first clk edge after deassert): all valid bits 0, out_valid 0, out_sum 0, out_ovf 0. in_ready returns to 1 once rst deasserts.
- Accept: handshake occurs at an edge where in_valid && in_ready.
- Latency: STAGES cycles from accept edge to out_valid high, assuming no stall. With STAGES=1, the result is valid in the cycle after accept.
- Throughput: one result per cycle while out_ready is held high.
- Stall: out_valid && !out_ready freezes the whole pipe. out_sum and out_ovf stay stable until the handshake edge.
- Simultaneous output handshake and input accept in the same cycle is legal and required for full throughput.
- rst asserted mid-operation: all in-flight operations are discarded immediately. out_valid drops asynchronously, and nothing in flight emerges after release.
- Wrap-around: an add overflow appears only in out_sum[WIDTH] and out_ovf; the low WIDTH bits wrap modulo 2^WIDTH.

## Configuration
- ADDER_PIPE_SUB_EN defined: in_sub is honoured as described.
- ADDER_PIPE_SUB_EN not defined: in_sub is ignored, B' = B, and carry-in = 0. The B-inversion muxes are removed.

## Structure
- Shared package adder_pkg holds:
  - the op enum op_e {OP_ADD, OP_SUB};
  - the helper function for chunk width;
  - a parameter-legality check (WIDTH % STAGES == 0).
- Sub-module adder_pipe_stage holds one CW-bit chunk adder with carry-in/out and its stage register. adder_pipe instantiates it STAGES times in a generate loop. The skew and deskew registers live in adder_pipe.

## Test plan
- 0xFFFF + 0x0001, add, out_ready = 1 → out_sum = 0x1_0000 and out_ovf = 0, 4 cycles after accept.
- 0x7FFF + 0x0001, add → out_sum = 0x0_8000, out_ovf = 1.
- 0x0005 − 0x0007, sub, with macro defined → out_sum = 0x0_FFFE (carry 0 = borrow), out_ovf = 0. With the macro undefined, the same stimulus → 0x0_000C.
- Eight back-to-back operations with out_ready low for cycles 5–7 → in_ready low during the stall, all 8 results delivered in order, out_sum stable while stalled.
- rst pulsed with 3 operations in flight → out_valid low immediately, no result appears afterwards, and the next accepted operation emerges after exactly 4 cycles.
- WIDTH=4, STAGES=1: exhaustive A, B add → out_sum = A + B for all 256 pairs, 1-cycle latency.
